// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings, FSM state enumeration and small op decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Divide operations have the upper op bit set.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // Signed operations have the lower op bit clear.
  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: compare the shifted partial remainder
// against the divisor, subtract when it fits and report the quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] diff_s;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    diff_s = {1'b0, rem_in} - {2'b00, divisor};
    q_bit  = ~diff_s[WIDTH+1];
    if (q_bit) begin
      rem_out = diff_s[WIDTH:0];
    end else begin
      rem_out = rem_in;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, followed by a sign fix-up.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

  mdu_state_e       state_r, state_nx_s;
  mdu_op_e          op_in_s, op_r;
  logic             a_neg_r, b_neg_r;
  logic [WIDTH-1:0] mag_b_r;     // multiplicand / divisor magnitude
  logic [WIDTH:0]   acc_r;       // product upper half / partial remainder
  logic [WIDTH-1:0] sh_r;        // multiplier shifting out / dividend-quotient
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, dz_r;
  logic             busy_nx_s, done_nx_s;

  logic             start_dz_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_rem_in_s, div_rem_s;
  logic             div_q_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;
  logic             res_neg_s;

  assign op_in_s = mdu_op_e'(op);
  assign hi      = hi_r;
  assign lo      = lo_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign dz      = dz_r;

  // Request decode: divide-by-zero detection and operand magnitudes.
  always_comb begin
    start_dz_s = op_is_div(op_in_s) && (b == ZERO_W);
    if (op_is_signed(op_in_s) && a[WIDTH-1]) begin
      mag_a_s = ZERO_W - a;
    end else begin
      mag_a_s = a;
    end
    if (op_is_signed(op_in_s) && b[WIDTH-1]) begin
      mag_b_s = ZERO_W - b;
    end else begin
      mag_b_s = b;
    end
  end

  // Next state plus the next values of the registered status outputs.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && start_dz_s) begin
          state_nx_s = ST_DONE;
        end else if (start) begin
          state_nx_s = ST_CALC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_SIGN;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_SIGN: state_nx_s = ST_DONE;
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
    busy_nx_s = (state_nx_s == ST_CALC) || (state_nx_s == ST_SIGN);
    done_nx_s = (state_nx_s == ST_DONE);
  end

  // State register and registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (div_rem_in_s),
    .divisor (mag_b_r),
    .rem_out (div_rem_s),
    .q_bit   (div_q_s)
  );

  // Per-iteration arithmetic and the signed fix-up of the finished result.
  always_comb begin
    // acc_r[WIDTH] is always zero during multiply, so adding it is harmless.
    if (sh_r[0]) begin
      mul_sum_s = acc_r + {1'b0, mag_b_r};
    end else begin
      mul_sum_s = acc_r + ZERO_W1;
    end
    div_rem_in_s = {acc_r[WIDTH-1:0], sh_r[WIDTH-1]};

    res_neg_s = a_neg_r ^ b_neg_r;
    prod_s    = {acc_r[WIDTH-1:0], sh_r};
    if (res_neg_s) begin
      prod_fix_s = ZERO_2W - prod_s;
      quo_fix_s  = ZERO_W - sh_r;
    end else begin
      prod_fix_s = prod_s;
      quo_fix_s  = sh_r;
    end
    // Remainder follows the sign of the dividend.
    if (a_neg_r) begin
      rem_fix_s = ZERO_W - acc_r[WIDTH-1:0];
    end else begin
      rem_fix_s = acc_r[WIDTH-1:0];
    end
    if (op_is_div(op_r)) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Datapath registers: latch on start, iterate in CALC, publish in SIGN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= MDU_MULT;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      mag_b_r <= ZERO_W;
      acc_r   <= ZERO_W1;
      sh_r    <= ZERO_W;
      cnt_r   <= {CW{1'b0}};
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op_in_s;
            a_neg_r <= op_is_signed(op_in_s) & a[WIDTH-1];
            b_neg_r <= op_is_signed(op_in_s) & b[WIDTH-1];
            mag_b_r <= mag_b_s;
            sh_r    <= mag_a_s;
            acc_r   <= ZERO_W1;
            cnt_r   <= {CW{1'b0}};
            if (start_dz_s) begin
              dz_r <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (op_is_div(op_r)) begin
            acc_r <= div_rem_s;
            sh_r  <= {sh_r[WIDTH-2:0], div_q_s};
          end else begin
            acc_r <= {1'b0, mul_sum_s[WIDTH:1]};
            sh_r  <= {mul_sum_s[0], sh_r[WIDTH-1:1]};
          end
        end
        ST_SIGN: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
          dz_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (WIDTH=32): a transaction-level reference
// model computes results with 64-bit arithmetic and the expected cycle at
// which done appears; a compare process checks every cycle, and directed
// cases pin known literal results.
module tb_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, dz;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void ref_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = ux * uy;      rh = p[63:32]; rl = p[31:0]; end
      2'b10: begin
        sq = sx / sy; sr = sx % sy;
        p = 64'(sq); rl = p[31:0];
        p = 64'(sr); rh = p[31:0];
      end
      default: begin
        p = ux / uy; rl = p[31:0];
        p = ux % uy; rh = p[31:0];
      end
    endcase
  endfunction

  // Model state: edges left until done, done flag, visible hi/lo/dz.
  int           m_wait = 0;
  bit           m_done = 1'b0;
  bit           m_dz   = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  // Transaction model: accepts start only when idle, done W+2 cycles later.
  always @(posedge clk or posedge rst) begin
    bit was_done;
    if (rst) begin
      m_wait = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_done = 1'b1; m_dz = 1'b0; m_hi = m_rhi; m_lo = m_rlo;
        end
      end else if (!was_done && start) begin
        if (op[1] && b == '0) begin
          m_done = 1'b1; m_dz = 1'b1;
        end else begin
          ref_calc(op, a, b, m_rhi, m_rlo);
          m_wait = W + 1;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("busy", 64'(busy), 64'(m_wait > 0));
      check("done", 64'(done), 64'(m_done));
      if (m_done) check("dz", 64'(dz), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Present a request for exactly one sampling edge, then scramble inputs.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Wait (bounded) for done; optionally throw junk starts while busy.
  task automatic wait_done(input bit noise, output int lat, output logic dz_seen);
    lat = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (noise && m_wait > 0) begin
        start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_within_bound", 64'(done), 64'd1);
    dz_seen = dz;
  endtask

  initial begin
    int           lat, seen;
    logic         dzs;
    logic [1:0]   o;
    logic [W-1:0] x, y;

    repeat (3) @(negedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // First start right after reset release.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, dzs);
    check("multu_latency", 64'(lat), 64'd34);
    check("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(1'b0, lat, dzs);
    check("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    @(negedge clk);

    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, lat, dzs);
    check("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("div_dz", 64'(dzs), 64'd0);
    @(negedge clk);

    issue(2'b11, 32'h0000_0007, 32'h0000_0000);
    wait_done(1'b0, lat, dzs);
    check("dz_latency", 64'(lat), 64'd1);
    check("dz_flag", 64'(dzs), 64'd1);
    check("dz_hi_held", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("dz_lo_held", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    @(negedge clk);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, dzs);
    check("ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    check("ovf_hi", 64'(hi), 64'd0);
    check("ovf_dz", 64'(dzs), 64'd0);
    @(negedge clk);

    // A start presented while done=1 must be dropped.
    issue(2'b01, 32'd3, 32'd4);
    wait_done(1'b0, lat, dzs);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_in_done_busy", 64'(busy), 64'd0);
    check("start_in_done_lo", 64'(lo), 64'd12);
    @(negedge clk);

    // Abort mid-calculation with reset.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Second start while busy is ignored; only the first result appears.
    issue(2'b00, 32'd100, 32'd7);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat, dzs);
    check("busy_start_lo", 64'(lo), 64'd700);
    check("busy_start_hi", 64'(hi), 64'd0);
    @(negedge clk);
    #1;
    check("no_queued_op", 64'(busy), 64'd0);
    @(negedge clk);

    // Randomized operations with corner-value bias and junk starts.
    repeat (300) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'd1;
        3: x = 32'($urandom_range(0, 15));
        4: y = 32'hFFFF_FFFF;
        default: begin end
      endcase
      issue(o, x, y);
      wait_done(1'b1, lat, dzs);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 a  input  WIDTH  multiplicand / dividend, sampled with start.
REQ-007 b  input  WIDTH  multiplier / divisor, sampled with start.
REQ-008 hi  output  WIDTH  product upper half / remainder.
REQ-009 lo  output  WIDTH  product lower half / quotient.
REQ-010 busy  output  1  high in CALC and SIGN.
REQ-011 done  output  1  one-cycle completion pulse (DONE state).
REQ-012 dz  output  1  divide-by-zero flag, valid while done=1.

Function
REQ-013 FSM states are IDLE, CALC, SIGN and DONE.
REQ-014 IDLE: start=1 latches a, b and op, loads the operand magnitudes (signed ops: absolute value; unsigned: raw), clears the iteration counter, and moves to CALC.
REQ-015 IDLE with start=1, a div/divu op and b=0 moves directly to DONE with dz=1; hi/lo stay unchanged.
REQ-016 CALC runs exactly WIDTH cycles, one bit per cycle: mult uses radix-2 shift-add; div uses restoring subtract-shift with a WIDTH+1-bit partial remainder.
REQ-017 The cycle after the last CALC iteration moves to SIGN.
REQ-018 SIGN: for signed ops, the product is negated (2*WIDTH bits) when a and b signs differ; the quotient is negated when the signs differ; the remainder takes the sign of a.
REQ-019 On the SIGN->DONE edge, hi/lo load the result and dz is 0.
REQ-020 DONE lasts one cycle with done=1, then returns to IDLE; a start seen in DONE is ignored.
REQ-021 Latency: when start is sampled at edge N, done=1 in cycle N+WIDTH+2; for the divide-by-zero case, done=1 in cycle N+1.
REQ-022 start is ignored while busy=1 or done=1; no queuing.
REQ-023 Signed div of most-negative by -1: lo=most-negative, hi=0, dz=0; no trap.
REQ-024 Signed quotient truncates toward zero.
REQ-025 hi/lo hold their value between operations; they change only on SIGN->DONE.
REQ-026 op and operands changing while busy do not affect the result in flight.

Reset
REQ-027 rst=1 forces IDLE, hi=0, lo=0, busy=0, done=0, dz=0 and clears the internal registers, asynchronously.
REQ-028 rst asserted mid-operation aborts it; no done pulse follows.
REQ-029 The first start is honored on the first rising edge after rst deasserts.

Structure
REQ-030 Package mdu_pkg holds the op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the state enumeration.
REQ-031 The single-bit restoring division step is the sub-module mdu_div_step (combinational: remainder, divisor -> next remainder, quotient bit).
REQ-032 Iteration counter width is $clog2(WIDTH)+1.
REQ-033 Implementation is 120-400 lines of RTL; no multiplier or divider primitives inferred.

Verification
REQ-034 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dz=0.
REQ-037 divu a=7, b=0 -> done and dz=1 the next cycle, hi/lo unchanged from the previous op.
REQ-038 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-039 Reset and re-start: rst pulsed at CALC cycle 10 -> busy=0, hi=lo=0, no done; a second start during busy is ignored and only the first result appears.
